// File: rtl/pwm_ramp_ctrl.sv
// Soft-start / soft-stop ramp sequencer for one PWM channel.
// Optional fault input and FAULT state: define PWM_RAMP_FAULT_EN.
module pwm_ramp_ctrl #(
  parameter int CW = 16,
  parameter int HW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          stop,
  input  logic [CW-1:0] target_cmp,
  input  logic [CW-1:0] step,
  input  logic [HW-1:0] hold_periods,
  input  logic          period_evt,
`ifdef PWM_RAMP_FAULT_EN
  input  logic          fault,
`endif
  output logic [CW-1:0] compare,
  output logic          pwm_en,
  output logic          busy,
  output logic          at_target,
  output logic          done,
  output logic [2:0]    state
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_RAMP = 3'd1;
  localparam logic [2:0] S_RUN  = 3'd2;
  localparam logic [2:0] S_STOP = 3'd3;
`ifdef PWM_RAMP_FAULT_EN
  localparam logic [2:0] S_FAULT = 3'd4;
`endif

  logic [2:0]    state_d;
  logic [CW-1:0] tgt_q;
  logic [CW-1:0] tgt_d;
  logic [CW-1:0] compare_d;
  logic          pwm_en_d;
  logic          done_d;
  logic          busy_d;
  logic          at_target_d;
  logic [HW-1:0] hold_cnt;
  logic          fault_i;
  logic          tick;
  logic          accept;
  logic          ramp_tick;
  logic [CW:0]   sum;
  logic [CW:0]   diff;
  logic [CW-1:0] up_v;
  logic [CW-1:0] dn_sat;
  logic [CW-1:0] dn_v;
  logic [CW-1:0] toward;
  logic [CW-1:0] stop_v;

`ifdef PWM_RAMP_FAULT_EN
  assign fault_i = fault;
`else
  assign fault_i = 1'b0;
`endif

  assign tick = pwm_en & period_evt
              & (hold_cnt == hold_periods);

  assign accept = (state == S_IDLE) & start
                & ~stop & ~fault_i;

  // RUN only re-enters the ramp when the command moved.
  assign ramp_tick = tick
    & ((state == S_RAMP)
    | ((state == S_RUN) & (target_cmp != compare)));

  assign tgt_d = (accept | ramp_tick) ? target_cmp : tgt_q;

  // One extra bit keeps the step arithmetic from wrapping.
  assign sum  = {1'b0, compare} + {1'b0, step};
  assign diff = {1'b0, compare} - {1'b0, step};

  assign up_v = (sum > {1'b0, tgt_d}) ? tgt_d
                                      : sum[CW-1:0];
  assign dn_sat = diff[CW] ? '0 : diff[CW-1:0];
  assign dn_v   = (dn_sat < tgt_d) ? tgt_d : dn_sat;

  assign toward = (step == '0)      ? tgt_d :
                  (compare < tgt_d) ? up_v  :
                  (compare > tgt_d) ? dn_v  :
                                      compare;

  assign stop_v = ((step == '0) | diff[CW]) ? '0
                                            : diff[CW-1:0];

  // Carrier-period divider, restarted whenever a new ramp begins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_cnt <= '0;
    end else if (accept) begin
      hold_cnt <= '0;
    end else if (pwm_en && period_evt) begin
      hold_cnt <= tick ? '0 : hold_cnt + 1'b1;
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      compare   <= '0;
      pwm_en    <= 1'b0;
      done      <= 1'b0;
      busy      <= 1'b0;
      at_target <= 1'b0;
      tgt_q     <= '0;
    end else begin
      state     <= state_d;
      compare   <= compare_d;
      pwm_en    <= pwm_en_d;
      done      <= done_d;
      busy      <= busy_d;
      at_target <= at_target_d;
      tgt_q     <= tgt_d;
    end
  end

  // Next-state selection; stop overrides a concurrent tick, fault everything.
  always_comb begin
    state_d = state;
    unique case (state)
      S_IDLE: begin
        if (accept)
          state_d = (target_cmp == '0) ? S_RUN : S_RAMP;
      end
      S_RAMP, S_RUN: begin
        if (ramp_tick)
          state_d = (toward == tgt_d) ? S_RUN : S_RAMP;
        if (stop)
          state_d = S_STOP;
      end
      S_STOP: begin
        if (tick && compare == '0)
          state_d = S_IDLE;
      end
`ifdef PWM_RAMP_FAULT_EN
      S_FAULT: begin
        if (!fault && !start && stop)
          state_d = S_IDLE;
      end
`endif
      default: state_d = S_IDLE;
    endcase
`ifdef PWM_RAMP_FAULT_EN
    if (fault_i)
      state_d = S_FAULT;
`endif
  end

  // Next compare / enable / done, plus status flags derived from state_d.
  always_comb begin
    compare_d = compare;
    pwm_en_d  = pwm_en;
    done_d    = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (accept)
          pwm_en_d = 1'b1;
      end
      S_RAMP, S_RUN: begin
        if (ramp_tick)
          compare_d = toward;
      end
      S_STOP: begin
        if (tick) begin
          if (compare == '0) begin
            pwm_en_d = 1'b0;
            done_d   = 1'b1;
          end else begin
            compare_d = stop_v;
          end
        end
      end
      default: ;
    endcase
    if (fault_i) begin
      compare_d = '0;
      pwm_en_d  = 1'b0;
      done_d    = 1'b0;
    end
    busy_d      = (state_d == S_RAMP)
                | (state_d == S_STOP);
    at_target_d = (state_d == S_RUN);
  end

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Bench for pwm_ramp_ctrl: vector table, corner sequences,
// and random traffic against a behavioural model.
module tb_pwm_ramp_ctrl;
  localparam int CW = 16;
  localparam int HW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          stop;
  logic [CW-1:0] target_cmp;
  logic [CW-1:0] step;
  logic [HW-1:0] hold_periods;
  logic          period_evt;
`ifdef PWM_RAMP_FAULT_EN
  logic          fault;
`endif
  logic [CW-1:0] compare;
  logic          pwm_en;
  logic          busy;
  logic          at_target;
  logic          done;
  logic [2:0]    state;

  int vectors = 0;
  int miscompares = 0;

  int m_state, m_cmp, m_en, m_done, m_hc;

  typedef struct {
    int st; int sp; int pe;
    int tgt; int stp; int hold;
    int e_cmp; int e_en; int e_state; int e_done;
  } vec_t;

  vec_t tbl[$];

  pwm_ramp_ctrl #(.CW(CW), .HW(HW)) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .stop(stop),
    .target_cmp(target_cmp),
    .step(step),
    .hold_periods(hold_periods),
    .period_evt(period_evt),
`ifdef PWM_RAMP_FAULT_EN
    .fault(fault),
`endif
    .compare(compare),
    .pwm_en(pwm_en),
    .busy(busy),
    .at_target(at_target),
    .done(done),
    .state(state)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name,
                       input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d",
               name, act, exp);
    end
  endtask

  function automatic int toward(int cur, int tgt, int stp);
    if (stp == 0) return tgt;
    if (cur < tgt) return (cur + stp > tgt) ? tgt : cur + stp;
    if (cur > tgt) return (cur - stp < tgt) ? tgt : cur - stp;
    return cur;
  endfunction

  task automatic model_reset();
    m_state = 0; m_cmp = 0; m_en = 0; m_done = 0; m_hc = 0;
  endtask

  task automatic model_step();
    int ns, nc, ne, nd, nh, tg, sp, hd;
    bit tick;
    ns = m_state; nc = m_cmp; ne = m_en; nd = 0; nh = m_hc;
    tg = int'(target_cmp);
    sp = int'(step);
    hd = int'(hold_periods);
    tick = (m_en == 1) && period_evt && (m_hc == hd);
    if (m_en == 1 && period_evt)
      nh = tick ? 0 : (m_hc + 1) % 256;
    case (m_state)
      0: if (start && !stop) begin
        ne = 1; nh = 0; ns = (tg == 0) ? 2 : 1;
      end
      1, 2: begin
        if (tick && (m_state == 1 || tg != m_cmp)) begin
          nc = toward(m_cmp, tg, sp);
          ns = (nc == tg) ? 2 : 1;
        end
        if (stop) ns = 3;
      end
      3: if (tick) begin
        if (m_cmp == 0) begin
          ne = 0; nd = 1; ns = 0;
        end else begin
          nc = (sp == 0 || m_cmp <= sp) ? 0 : m_cmp - sp;
        end
      end
`ifdef PWM_RAMP_FAULT_EN
      4: if (!fault && !start && stop) ns = 0;
`endif
      default: ;
    endcase
`ifdef PWM_RAMP_FAULT_EN
    if (fault) begin
      ns = 4; nc = 0; ne = 0; nd = 0;
      if (m_state == 0) nh = m_hc;
    end
`endif
    m_state = ns; m_cmp = nc; m_en = ne;
    m_done = nd; m_hc = nh;
  endtask

  task automatic check_model();
    check("model.compare", int'(compare), m_cmp);
    check("model.pwm_en", int'(pwm_en), m_en);
    check("model.state", int'(state), m_state);
    check("model.done", int'(done), m_done);
    check("model.busy", int'(busy),
          (m_state == 1 || m_state == 3) ? 1 : 0);
    check("model.at_target", int'(at_target),
          (m_state == 2) ? 1 : 0);
  endtask

  task automatic drive(input int st, input int sp,
                       input int tg, input int stp,
                       input int hd, input int pe);
    start        = st[0];
    stop         = sp[0];
    target_cmp   = tg[CW-1:0];
    step         = stp[CW-1:0];
    hold_periods = hd[HW-1:0];
    period_evt   = pe[0];
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    check_model();
  endtask

  initial begin
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
`ifdef PWM_RAMP_FAULT_EN
    fault = 1'b0;
`endif
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst.compare", int'(compare), 0);
    check("rst.pwm_en", int'(pwm_en), 0);
    check("rst.busy", int'(busy), 0);
    check("rst.at_target", int'(at_target), 0);
    check("rst.done", int'(done), 0);
    check("rst.state", int'(state), 0);
    reset = 1'b0;

    // soft start 0..450 by 100, tick every 2nd period
    tbl.push_back('{1, 0, 0, 450, 100, 1, 0, 1, 1, 0});
    tbl.push_back('{0, 0, 1, 450, 100, 1, 0, 1, 1, 0});
    tbl.push_back('{0, 0, 1, 450, 100, 1, 100, 1, 1, 0});
    tbl.push_back('{0, 0, 0, 450, 100, 1, 100, 1, 1, 0});
    tbl.push_back('{0, 0, 1, 450, 100, 1, 100, 1, 1, 0});
    tbl.push_back('{0, 0, 1, 450, 100, 1, 200, 1, 1, 0});
    tbl.push_back('{0, 0, 1, 450, 100, 1, 200, 1, 1, 0});
    tbl.push_back('{0, 0, 1, 450, 100, 1, 300, 1, 1, 0});
    tbl.push_back('{0, 0, 1, 450, 100, 1, 300, 1, 1, 0});
    tbl.push_back('{0, 0, 1, 450, 100, 1, 400, 1, 1, 0});
    tbl.push_back('{0, 0, 1, 450, 100, 1, 400, 1, 1, 0});
    tbl.push_back('{0, 0, 1, 450, 100, 1, 450, 1, 2, 0});
    tbl.push_back('{0, 0, 0, 450, 100, 1, 450, 1, 2, 0});
    // soft stop 450 by 200, tick every period
    tbl.push_back('{0, 1, 0, 450, 200, 0, 450, 1, 3, 0});
    tbl.push_back('{0, 0, 1, 450, 200, 0, 250, 1, 3, 0});
    tbl.push_back('{0, 0, 1, 450, 200, 0, 50, 1, 3, 0});
    tbl.push_back('{0, 0, 1, 450, 200, 0, 0, 1, 3, 0});
    tbl.push_back('{0, 0, 0, 450, 200, 0, 0, 1, 3, 0});
    tbl.push_back('{0, 0, 1, 450, 200, 0, 0, 0, 0, 1});
    tbl.push_back('{0, 0, 0, 450, 200, 0, 0, 0, 0, 0});
    // start+stop together, stop alone: IDLE holds
    tbl.push_back('{1, 1, 1, 450, 200, 0, 0, 0, 0, 0});
    tbl.push_back('{0, 1, 1, 450, 200, 0, 0, 0, 0, 0});

    foreach (tbl[i]) begin
      drive(tbl[i].st, tbl[i].sp, tbl[i].tgt,
            tbl[i].stp, tbl[i].hold, tbl[i].pe);
      cycle();
      check($sformatf("tbl%0d.compare", i),
            int'(compare), tbl[i].e_cmp);
      check($sformatf("tbl%0d.pwm_en", i),
            int'(pwm_en), tbl[i].e_en);
      check($sformatf("tbl%0d.state", i),
            int'(state), tbl[i].e_state);
      check($sformatf("tbl%0d.done", i),
            int'(done), tbl[i].e_done);
    end

    // step=0 jumps straight to target on the first tick
    drive(1, 0, 1234, 0, 0, 0); cycle();
    check("jump.pre", int'(compare), 0);
    drive(0, 0, 1234, 0, 0, 1); cycle();
    check("jump.cmp", int'(compare), 1234);
    check("jump.run", int'(at_target), 1);

    // retarget in RUN: 450 -> 100 by 150
    drive(0, 0, 450, 0, 0, 1); cycle();
    check("rt.450", int'(compare), 450);
    drive(0, 0, 100, 150, 0, 1); cycle();
    check("rt.300", int'(compare), 300);
    check("rt.ramp", int'(state), 1);
    cycle();
    check("rt.150", int'(compare), 150);
    cycle();
    check("rt.100", int'(compare), 100);
    check("rt.run", int'(state), 2);

    // saturation near full scale
    drive(0, 0, 32768, 0, 0, 1); cycle();
    drive(0, 0, 65535, 36864, 0, 1); cycle();
    check("sat.cmp", int'(compare), 65535);
    check("sat.state", int'(state), 2);

    // step=0 stop: straight to 0, then disable
    drive(0, 1, 65535, 0, 0, 0); cycle();
    drive(0, 0, 65535, 0, 0, 1); cycle();
    check("stop0.cmp", int'(compare), 0);
    cycle();
    check("stop0.done", int'(done), 1);
    check("stop0.en", int'(pwm_en), 0);

    // async reset mid-ramp at compare=300
    drive(1, 0, 450, 100, 0, 0); cycle();
    drive(0, 0, 450, 100, 0, 1);
    repeat (3) cycle();
    check("arst.pre", int'(compare), 300);
    #3;
    reset = 1'b1;
    #1;
    check("arst.compare", int'(compare), 0);
    check("arst.pwm_en", int'(pwm_en), 0);
    check("arst.state", int'(state), 0);
    check("arst.busy", int'(busy), 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    drive(1, 0, 200, 0, 0, 0); cycle();
    check("arst.restart", int'(pwm_en), 1);
    drive(0, 0, 200, 0, 0, 1); cycle();
    check("arst.run", int'(compare), 200);

`ifdef PWM_RAMP_FAULT_EN
    drive(0, 0, 450, 100, 0, 1); cycle();
    fault = 1'b1; cycle();
    check("flt.cmp", int'(compare), 0);
    check("flt.en", int'(pwm_en), 0);
    check("flt.state", int'(state), 4);
    fault = 1'b0;
    drive(1, 0, 450, 100, 0, 1); cycle();
    check("flt.hold", int'(state), 4);
    drive(0, 1, 450, 100, 0, 1); cycle();
    check("flt.ack", int'(state), 0);
`endif

    // random traffic
    drive(0, 1, 0, 0, 0, 0); cycle();
    begin
      int tg, sp, hd;
      tg = 500; sp = 50; hd = 0;
      for (int n = 0; n < 3000; n++) begin
        if ($urandom_range(0, 7) == 0)
          tg = ($urandom_range(0, 3) == 0)
             ? 65535 - $urandom_range(0, 3)
             : $urandom_range(0, 65535);
        if ($urandom_range(0, 15) == 0)
          sp = ($urandom_range(0, 3) == 0)
             ? 0 : $urandom_range(1, 20000);
        if ($urandom_range(0, 63) == 0)
          hd = $urandom_range(0, 3);
        drive(($urandom_range(0, 9) == 0) ? 1 : 0,
              ($urandom_range(0, 29) == 0) ? 1 : 0,
              tg, sp, hd, $urandom_range(0, 1));
`ifdef PWM_RAMP_FAULT_EN
        fault = ($urandom_range(0, 199) == 0);
`endif
        cycle();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
